// File: rtl/l1a_match_fifo.sv
// L1A event numbering, fine-delay alignment with L1A_MATCH, and a FWFT FIFO of
// {match, event number} words for the DAQ readout controller.
module l1a_match_fifo #(
  parameter int DEPTH = 16,
  parameter int CNT_W = 24
) (
  input  logic                     CLK,
  input  logic                     RST_N,
  input  logic                     L1A,
  input  logic                     L1A_MATCH,
  input  logic [3:0]               L1FD,
  input  logic                     L1A_CNT_RST,
  input  logic                     RD_EN,
  output logic [CNT_W:0]           DOUT,
  output logic                     DVALID,
  output logic                     FULL,
  output logic [$clog2(DEPTH):0]   WORDS,
  output logic                     OVERFLOW,
  output logic [15:0]              MATCH_CNT
);

  localparam int AW = $clog2(DEPTH);
  localparam int DW = CNT_W + 1;

  logic [CNT_W-1:0]             cnt_q, cnt_d, l1a_num;
  logic [15:0]                  sl_vld_q, sl_vld_d;
  logic [15:0][CNT_W-1:0]       sl_num_q, sl_num_d;

  logic                         wr_vld, wr_ok, rd_ok;
  logic [DW-1:0]                wr_word;
  logic [DW-1:0]                mem [DEPTH];
  logic [AW-1:0]                wptr_q, wptr_d, rptr_q, rptr_d;
  logic [AW:0]                  words_q, words_d;
  logic                         full_q, full_d;
  logic                         ovf_q, ovf_d;
  logic [DW-1:0]                dout_q, dout_d;
  logic [15:0]                  match_cnt_q, match_cnt_d;

  always_comb begin
    l1a_num = L1A_CNT_RST ? CNT_W'(1) : cnt_q + CNT_W'(1);
    cnt_d   = cnt_q;
    if (L1A)
      cnt_d = l1a_num;
    else if (L1A_CNT_RST)
      cnt_d = '0;

    // stage k holds an L1A from k+1 clocks ago, so stage L1FD lines up with its match
    sl_vld_d = {sl_vld_q[14:0], L1A};
    sl_num_d = {sl_num_q[14:0], l1a_num};
    wr_vld   = sl_vld_q[L1FD];
    wr_word  = {L1A_MATCH, sl_num_q[L1FD]};

    rd_ok   = RD_EN && (words_q != '0);
    wr_ok   = wr_vld && (!full_q || rd_ok);
    wptr_d  = wptr_q + AW'(wr_ok);
    rptr_d  = rptr_q + AW'(rd_ok);
    words_d = words_q + (AW+1)'(wr_ok) - (AW+1)'(rd_ok);
    full_d  = (words_d == (AW+1)'(DEPTH));
    ovf_d   = ovf_q || (wr_vld && !wr_ok);

    // registered head word; the slot being written this edge is not yet in mem
    dout_d = dout_q;
    if (words_d != '0) begin
      if (wr_ok && (wptr_q == rptr_d))
        dout_d = wr_word;
      else
        dout_d = mem[rptr_d];
    end

    match_cnt_d = match_cnt_q;
    if (wr_ok && L1A_MATCH && (match_cnt_q != 16'hFFFF))
      match_cnt_d = match_cnt_q + 16'd1;
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      cnt_q       <= '0;
      sl_vld_q    <= '0;
      sl_num_q    <= '0;
      wptr_q      <= '0;
      rptr_q      <= '0;
      words_q     <= '0;
      full_q      <= 1'b0;
      ovf_q       <= 1'b0;
      dout_q      <= '0;
      match_cnt_q <= '0;
    end else begin
      cnt_q       <= cnt_d;
      sl_vld_q    <= sl_vld_d;
      sl_num_q    <= sl_num_d;
      wptr_q      <= wptr_d;
      rptr_q      <= rptr_d;
      words_q     <= words_d;
      full_q      <= full_d;
      ovf_q       <= ovf_d;
      dout_q      <= dout_d;
      match_cnt_q <= match_cnt_d;
    end
  end

  always_ff @(posedge CLK) begin
    if (wr_ok)
      mem[wptr_q] <= wr_word;
  end

  assign DOUT      = dout_q;
  assign DVALID    = (words_q != '0);
  assign FULL      = full_q;
  assign WORDS     = words_q;
  assign OVERFLOW  = ovf_q;
  assign MATCH_CNT = match_cnt_q;

endmodule

// File: tb/tb_l1a_match_fifo.sv
// Scenario bench for l1a_match_fifo: expected words are queued when L1As are
// driven and compared as the readout side pops them.
module tb_l1a_match_fifo;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        l1a = 1'b0;
  logic        l1a_match = 1'b0;
  logic [3:0]  l1fd = 4'd0;
  logic        l1a_cnt_rst = 1'b0;
  logic        rd_en = 1'b0;
  logic [24:0] dout;
  logic        dvalid;
  logic        full;
  logic [4:0]  words;
  logic        overflow;
  logic [15:0] match_cnt;

  int          n_checks = 0;
  int          n_fail = 0;
  logic [24:0] sb [$];

  l1a_match_fifo #(.DEPTH(16), .CNT_W(24)) dut (
    .CLK(clk), .RST_N(rst_n), .L1A(l1a), .L1A_MATCH(l1a_match), .L1FD(l1fd),
    .L1A_CNT_RST(l1a_cnt_rst), .RD_EN(rd_en), .DOUT(dout), .DVALID(dvalid),
    .FULL(full), .WORDS(words), .OVERFLOW(overflow), .MATCH_CNT(match_cnt)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0; l1a = 1'b0; l1a_match = 1'b0; l1a_cnt_rst = 1'b0; rd_en = 1'b0;
    sb.delete();
    tick(2);
    rst_n = 1'b1;
    tick(1);
  endtask

  task automatic pop_and_score(input string tag);
    logic [24:0] exp_w;
    logic [24:0] last_w;
    int got;
    int budget;
    got = 0; budget = 0; last_w = '0;
    while (dvalid && budget < 64) begin
      n_checks++;
      if (sb.size() == 0) begin
        n_fail++;
        $display("FAIL %s extra_word: got %h, required no word", tag, dout);
      end else begin
        exp_w = sb.pop_front();
        if (dout !== exp_w) begin
          n_fail++;
          $display("FAIL %s dout: got %h, required %h", tag, dout, exp_w);
        end
      end
      last_w = dout;
      got++;
      rd_en = 1'b1;
      tick();
      rd_en = 1'b0;
      budget++;
    end
    n_checks++;
    if (sb.size() != 0) begin
      n_fail++;
      $display("FAIL %s missing_words: got %0d still expected, required 0", tag, sb.size());
      sb.delete();
    end
    if (got > 0) begin
      n_checks++;
      if (dout !== last_w) begin
        n_fail++;
        $display("FAIL %s dout_hold_when_empty: got %h, required %h", tag, dout, last_w);
      end
    end
  endtask

  task automatic test_reset();
    do_reset();
    n_checks++; if (dout !== 25'h0) begin n_fail++; $display("FAIL rst_dout: got %h, required 0", dout); end
    n_checks++; if (dvalid !== 1'b0) begin n_fail++; $display("FAIL rst_dvalid: got %b, required 0", dvalid); end
    n_checks++; if (full !== 1'b0) begin n_fail++; $display("FAIL rst_full: got %b, required 0", full); end
    n_checks++; if (words !== 5'd0) begin n_fail++; $display("FAIL rst_words: got %0d, required 0", words); end
    n_checks++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL rst_overflow: got %b, required 0", overflow); end
    n_checks++; if (match_cnt !== 16'd0) begin n_fail++; $display("FAIL rst_match_cnt: got %0d, required 0", match_cnt); end
    rd_en = 1'b1;
    tick(3);
    rd_en = 1'b0;
    n_checks++; if (words !== 5'd0 || dvalid !== 1'b0) begin
      n_fail++; $display("FAIL underflow_ignored: got words=%0d dvalid=%b, required 0/0", words, dvalid);
    end
  endtask

  task automatic test_single();
    do_reset();
    l1fd = 4'd0;
    tick(3);
    l1a = 1'b1;
    sb.push_back({1'b1, 24'h000001});
    tick();
    l1a = 1'b0; l1a_match = 1'b1;
    n_checks++; if (dvalid !== 1'b0) begin n_fail++; $display("FAIL single_early_dvalid: got %b, required 0", dvalid); end
    tick();
    l1a_match = 1'b0;
    n_checks++; if (dvalid !== 1'b1) begin n_fail++; $display("FAIL single_dvalid: got %b, required 1", dvalid); end
    n_checks++; if (dout !== 25'h1000001) begin n_fail++; $display("FAIL single_dout: got %h, required 1000001", dout); end
    n_checks++; if (words !== 5'd1) begin n_fail++; $display("FAIL single_words: got %0d, required 1", words); end
    n_checks++; if (match_cnt !== 16'd1) begin n_fail++; $display("FAIL single_match_cnt: got %0d, required 1", match_cnt); end
    pop_and_score("single");
  endtask

  task automatic test_burst();
    do_reset();
    l1fd = 4'd5;
    tick(2);
    sb.push_back({1'b0, 24'd1});
    sb.push_back({1'b1, 24'd2});
    sb.push_back({1'b0, 24'd3});
    l1a = 1'b1;
    tick(3);
    l1a = 1'b0;
    tick(4);
    l1a_match = 1'b1;
    n_checks++; if (words !== 5'd1) begin n_fail++; $display("FAIL burst_words_a: got %0d, required 1", words); end
    tick();
    l1a_match = 1'b0;
    n_checks++; if (words !== 5'd2) begin n_fail++; $display("FAIL burst_words_b: got %0d, required 2", words); end
    tick();
    n_checks++; if (words !== 5'd3) begin n_fail++; $display("FAIL burst_words_c: got %0d, required 3", words); end
    n_checks++; if (match_cnt !== 16'd1) begin n_fail++; $display("FAIL burst_match_cnt: got %0d, required 1", match_cnt); end
    pop_and_score("burst");
  endtask

  task automatic test_overflow();
    do_reset();
    l1fd = 4'd0;
    l1a_match = 1'b1;
    for (int k = 1; k <= 16; k++) sb.push_back({1'b1, 24'(k)});
    for (int i = 0; i < 18; i++) begin
      l1a = 1'b1;
      if (i == 17) begin
        n_checks++;
        if (full !== 1'b1 || overflow !== 1'b0 || words !== 5'd16) begin
          n_fail++;
          $display("FAIL ovf_at_16th: got full=%b ovf=%b words=%0d, required 1/0/16", full, overflow, words);
        end
      end
      tick();
    end
    l1a = 1'b0;
    tick(2);
    l1a_match = 1'b0;
    n_checks++; if (full !== 1'b1) begin n_fail++; $display("FAIL ovf_full: got %b, required 1", full); end
    n_checks++; if (words !== 5'd16) begin n_fail++; $display("FAIL ovf_words: got %0d, required 16", words); end
    n_checks++; if (overflow !== 1'b1) begin n_fail++; $display("FAIL ovf_flag: got %b, required 1", overflow); end
    n_checks++; if (match_cnt !== 16'd16) begin n_fail++; $display("FAIL ovf_match_cnt: got %0d, required 16", match_cnt); end
    pop_and_score("overflow");
    n_checks++; if (overflow !== 1'b1) begin n_fail++; $display("FAIL ovf_sticky: got %b, required 1", overflow); end
    n_checks++; if (full !== 1'b0 || words !== 5'd0) begin
      n_fail++; $display("FAIL ovf_drained: got full=%b words=%0d, required 0/0", full, words);
    end
  endtask

  task automatic test_full_rw();
    logic [24:0] exp_w;
    do_reset();
    l1fd = 4'd0;
    for (int k = 1; k <= 17; k++) sb.push_back({1'b0, 24'(k)});
    l1a = 1'b1;
    tick(17);
    l1a = 1'b0;
    n_checks++; if (full !== 1'b1) begin n_fail++; $display("FAIL fullrw_pre_full: got %b, required 1", full); end
    rd_en = 1'b1;
    exp_w = sb.pop_front();
    n_checks++; if (dout !== exp_w) begin n_fail++; $display("FAIL fullrw_head: got %h, required %h", dout, exp_w); end
    tick();
    rd_en = 1'b0;
    n_checks++; if (words !== 5'd16) begin n_fail++; $display("FAIL fullrw_words: got %0d, required 16", words); end
    n_checks++; if (full !== 1'b1) begin n_fail++; $display("FAIL fullrw_full: got %b, required 1", full); end
    n_checks++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL fullrw_overflow: got %b, required 0", overflow); end
    pop_and_score("full_rw");
  endtask

  task automatic test_back_to_back();
    logic [24:0] exp_w;
    do_reset();
    l1fd = 4'd2;
    tick(2);
    for (int k = 1; k <= 6; k++) sb.push_back({(k % 2 == 0), 24'(k)});
    rd_en = 1'b1;
    for (int o = 0; o <= 12; o++) begin
      l1a = (o < 6);
      l1a_match = (o >= 3 && o <= 8 && (o % 2 == 0));
      if (o >= 4 && o <= 9) begin
        n_checks++;
        if (words !== 5'd1 || dvalid !== 1'b1) begin
          n_fail++; $display("FAIL b2b_words_o%0d: got words=%0d dvalid=%b, required 1/1", o, words, dvalid);
        end
        if (sb.size() != 0) begin
          exp_w = sb.pop_front();
          n_checks++;
          if (dout !== exp_w) begin n_fail++; $display("FAIL b2b_dout_o%0d: got %h, required %h", o, dout, exp_w); end
        end
      end
      tick();
    end
    rd_en = 1'b0; l1a = 1'b0; l1a_match = 1'b0;
    n_checks++; if (words !== 5'd0 || sb.size() != 0) begin
      n_fail++; $display("FAIL b2b_end: got words=%0d left=%0d, required 0/0", words, sb.size());
    end
    n_checks++; if (match_cnt !== 16'd3) begin n_fail++; $display("FAIL b2b_match_cnt: got %0d, required 3", match_cnt); end
  endtask

  task automatic test_wrap();
    logic [6:0] l1a_seq;
    logic [6:0] rst_seq;
    do_reset();
    l1fd = 4'd3;
    tick(2);
    force dut.cnt_q = 24'hFFFFFE;
    #1;
    release dut.cnt_q;
    l1a_seq = 7'b1101111;
    rst_seq = 7'b0011000;
    sb.push_back({1'b0, 24'hFFFFFF});
    sb.push_back({1'b0, 24'h000000});
    sb.push_back({1'b0, 24'h000001});
    sb.push_back({1'b0, 24'h000001});
    sb.push_back({1'b0, 24'h000001});
    sb.push_back({1'b0, 24'h000002});
    for (int c = 0; c < 7; c++) begin
      l1a = l1a_seq[c];
      l1a_cnt_rst = rst_seq[c];
      tick();
    end
    l1a = 1'b0; l1a_cnt_rst = 1'b0;
    tick(8);
    n_checks++; if (words !== 5'd6) begin n_fail++; $display("FAIL wrap_words: got %0d, required 6", words); end
    pop_and_score("wrap");
  endtask

  task automatic test_reset_inflight();
    do_reset();
    l1fd = 4'd0;
    tick(2);
    l1a = 1'b1;
    tick(3);
    l1a = 1'b0;
    tick(3);
    n_checks++; if (words !== 5'd3) begin n_fail++; $display("FAIL rif_pre_words: got %0d, required 3", words); end
    tick(17);
    l1fd = 4'd8;
    l1a = 1'b1;
    tick(2);
    l1a = 1'b0;
    tick(2);
    #2;
    rst_n = 1'b0;
    #1;
    n_checks++; if (dvalid !== 1'b0) begin n_fail++; $display("FAIL rif_dvalid: got %b, required 0", dvalid); end
    n_checks++; if (words !== 5'd0) begin n_fail++; $display("FAIL rif_words: got %0d, required 0", words); end
    n_checks++; if (dout !== 25'h0) begin n_fail++; $display("FAIL rif_dout: got %h, required 0", dout); end
    tick(2);
    rst_n = 1'b1;
    for (int c = 0; c < 20; c++) begin
      tick();
      n_checks++;
      if (dvalid !== 1'b0 || words !== 5'd0) begin
        n_fail++; $display("FAIL rif_ghost_c%0d: got dvalid=%b words=%0d, required 0/0", c, dvalid, words);
      end
    end
    sb.push_back({1'b1, 24'd1});
    l1a = 1'b1;
    tick();
    l1a = 1'b0;
    tick(8);
    l1a_match = 1'b1;
    tick();
    l1a_match = 1'b0;
    n_checks++; if (dvalid !== 1'b1) begin n_fail++; $display("FAIL rif_next_dvalid: got %b, required 1", dvalid); end
    pop_and_score("reset_inflight");
  endtask

  task automatic test_latency();
    int fds [3];
    int n;
    fds = '{0, 7, 15};
    do_reset();
    for (int t = 0; t < 3; t++) begin
      tick(17);
      l1fd = 4'(fds[t]);
      tick();
      sb.push_back({1'b1, 24'(t + 1)});
      l1a = 1'b1;
      n = 0;
      for (int k = 1; k <= 40; k++) begin
        tick();
        l1a = 1'b0;
        l1a_match = (k == fds[t] + 1);
        n = k;
        if (dvalid) break;
      end
      l1a_match = 1'b0;
      n_checks++;
      if (!dvalid || n != fds[t] + 2) begin
        n_fail++; $display("FAIL latency_fd%0d: got %0d clocks (dvalid=%b), required %0d", fds[t], n, dvalid, fds[t] + 2);
      end
      pop_and_score("latency");
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_burst();
    test_overflow();
    test_full_rw();
    test_back_to_back();
    test_wrap();
    test_reset_inflight();
    test_latency();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/l1a_match_fifo.md
Name: l1a_match_fifo

Overview:
- Receiving end of the LCT/L1A matching path.
- Each L1A gets a running event number. The block waits the programmed fine-delay latency until that L1A's L1A_MATCH result arrives, then pairs the two.
- Each pair {match, event number} is stored in a first-word-fall-through FIFO for the readout logic.
- Sits between the LCT delay/match logic and the DAQ readout controller, and runs in the same CLK domain as both.

Parameters:
- DEPTH, 16, number of FIFO entries; must be a power of 2, minimum 4.
- CNT_W, 24, width of the L1A event number.

Ports:
- CLK  in  1  system clock; all logic is on the rising edge.
- RST_N  in  1  reset, asynchronous and active-low.
- L1A  in  1  L1A pulse, one clock per trigger; may be high on consecutive clocks.
- L1A_MATCH  in  1  match result; valid exactly L1FD+1 clocks after the corresponding L1A.
- L1FD  in  4  L1A fine delay (0-15); the same value drives the match logic.
- L1A_CNT_RST  in  1  synchronous clear of the event counter (TTC event-counter reset).
- RD_EN  in  1  readout pop request.
- DOUT  out  CNT_W+1  FIFO head word; bit CNT_W is the match flag, bits CNT_W-1:0 are the event number.
- DVALID  out  1  FIFO not empty; DOUT is valid.
- FULL  out  1  FIFO holds DEPTH words.
- WORDS  out  log2(DEPTH)+1  current FIFO occupancy.
- OVERFLOW  out  1  sticky flag; at least one event was dropped.
- MATCH_CNT  out  16  number of stored events with match=1; saturates at 16'hFFFF.

Behaviour:
- Reset (RST_N low, asynchronous):
  - Event counter is 0; the alignment line is cleared, so in-flight L1As are discarded.
  - FIFO is empty; DOUT=0, DVALID=0, FULL=0, WORDS=0, OVERFLOW=0, MATCH_CNT=0.
  - Reset released mid-stream: the first event counted is the first L1A seen at or after the first clock edge with RST_N high.
- Event counter:
  - On an L1A clock, cnt <= cnt+1. The number assigned to that L1A is the post-increment value, so the first L1A after reset is 1.
  - Wraps from 2^CNT_W-1 to 0.
  - L1A_CNT_RST alone sets cnt <= 0.
  - L1A_CNT_RST together with L1A sets cnt <= 1, and that L1A is numbered 1.
- Alignment:
  - L1A and its assigned number enter a 16-stage shift line (valid bit plus CNT_W number per stage).
  - The stage selected by L1FD emerges exactly L1FD+1 clocks after the L1A clock.
  - In that emerging cycle, L1A_MATCH is sampled, and the word {L1A_MATCH, number} is written at the same edge.
  - One write per clock at most; back-to-back L1As produce back-to-back writes.
- L1FD changes are allowed only while no L1A has occurred in the preceding 16 clocks. Otherwise, in-flight events may be lost or duplicated; this is documented and not checked.
- FIFO (FWFT):
  - DVALID = not empty; DOUT shows the head word. DOUT holds its last value when empty.
  - RD_EN with DVALID=1 pops the head at that edge. RD_EN with DVALID=0 is ignored, with no underflow and no state change.
  - Write into an empty FIFO: DVALID rises the clock after the write edge (no same-cycle bypass).
  - Write with FULL=1 and no read: the word is dropped, OVERFLOW is set and stays set until reset, and MATCH_CNT is not incremented.
  - Write and read in the same cycle with FULL=1: both happen; occupancy stays DEPTH and nothing is dropped.
  - Write and read in the same cycle otherwise: both happen; WORDS is unchanged.
  - Read and write pointers wrap modulo DEPTH. FULL and WORDS are registered and consistent with the pointers every cycle.
- MATCH_CNT increments on each stored write with match=1 and holds at 16'hFFFF.
- Latency from L1A to DVALID, with the FIFO empty: L1FD+2 clocks.

Test Plan:
- Reset, then L1FD=0; L1A at cycle 10, L1A_MATCH=1 at cycle 11 -> DVALID=1 at cycle 12, DOUT={1, 24'h000001}, WORDS=1, MATCH_CNT=1.
- L1FD=5; L1As at cycles 20, 21, 22; L1A_MATCH high only at cycle 27 -> writes at 26, 27, 28; words read out {0,1}, {1,2}, {0,3}; MATCH_CNT=1.
- DEPTH=16, RD_EN=0; 18 L1As -> FULL=1 after the 16th write, events 17 and 18 dropped, OVERFLOW=1, WORDS=16; then pop all -> event numbers 1..16 in order, OVERFLOW still 1.
- FULL=1 with RD_EN=1 while a write arrives -> the write is accepted, WORDS stays 16, OVERFLOW is not set by that cycle.
- Preload the counter to 2^24-1 via 2^24-1 L1As (or a forced value); next L1A -> number 0. L1A_CNT_RST together with L1A -> that event numbered 1.
- RST_N asserted with 3 events in the FIFO and 2 L1As in flight (L1FD=8) -> immediately DVALID=0, WORDS=0; no writes after release; next L1A numbered 1.
